// File: rtl/flash_reader_pkg.sv
// Shared definitions for the SPI NOR flash reader: SB_SPI register map,
// status-register bit positions, fixed register values and the FSM encoding.
package flash_reader_pkg;

    // SB_SPI register indices on the 4-bit flash register bus
    localparam logic [3:0] SPI_CR0  = 4'h8;
    localparam logic [3:0] SPI_CR1  = 4'h9;
    localparam logic [3:0] SPI_CR2  = 4'hA;
    localparam logic [3:0] SPI_BR   = 4'hB;
    localparam logic [3:0] SPI_SR   = 4'hC;
    localparam logic [3:0] SPI_TXDR = 4'hD;
    localparam logic [3:0] SPI_RXDR = 4'hE;
    localparam logic [3:0] SPI_CSR  = 4'hF;

    // Status register flags
    localparam int SR_TRDY = 4;
    localparam int SR_RRDY = 3;

    // Fixed register values written by the sequencer
    localparam logic [7:0] CR1_ENABLE  = 8'h80;
    localparam logic [7:0] CSR_CS_HIGH = 8'hFF;
    localparam logic [7:0] CSR_CS_LOW  = 8'hFE;
    localparam logic [7:0] DUMMY_BYTE  = 8'h00;

    // Sequencer states. POLL_T/TX/POLL_R/RX form the byte-exchange
    // subroutine; the state after RX comes from the return-state register.
    typedef enum logic [3:0] {
        ST_INIT_CR1 = 4'd0,
        ST_INIT_CSR = 4'd1,
        ST_IDLE     = 4'd2,
        ST_CS_LO    = 4'd3,
        ST_POLL_T   = 4'd4,
        ST_TX       = 4'd5,
        ST_POLL_R   = 4'd6,
        ST_RX       = 4'd7,
        ST_NEXT     = 4'd8,
        ST_VALID    = 4'd9,
        ST_CS_HI    = 4'd10
    } state_e;

    // Address byte sent after the opcode: index 0 = A[23:16], 1 = A[15:8], 2 = A[7:0]
    function automatic logic [7:0] addr_byte(input logic [23:0] addr, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = addr[23:16];
            2'd1:    b = addr[15:8];
            default: b = addr[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/flash_reg_port.sv
// Single-access engine for the flash register bus. Takes one read or write
// request, holds en/wr/addr/wdata stable until ack, drops en the following
// cycle and returns a one-cycle done pulse with the captured read data.
// A new request is never accepted in the done cycle, which guarantees at
// least one idle bus cycle between accesses.
module flash_reg_port (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic       wr,
    input  logic [3:0] addr,
    input  logic [7:0] wdata,
    output logic       done,
    output logic [7:0] rdata,
    output logic       fl_en,
    output logic       fl_wr,
    output logic [3:0] fl_addr,
    output logic [7:0] fl_wdata,
    input  logic       fl_ack,
    input  logic [7:0] fl_rdata
);

    logic       en_r;
    logic       wr_r;
    logic [3:0] addr_r;
    logic [7:0] wdata_r;
    logic       done_r;
    logic [7:0] rdata_r;

    // Launch an access on request, hold it until ack, then release the bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_r    <= 1'b0;
            wr_r    <= 1'b0;
            addr_r  <= 4'h0;
            wdata_r <= 8'h00;
            done_r  <= 1'b0;
            rdata_r <= 8'h00;
        end else begin
            done_r <= 1'b0;
            if (en_r) begin
                if (fl_ack) begin
                    en_r    <= 1'b0;
                    wr_r    <= 1'b0;
                    done_r  <= 1'b1;
                    rdata_r <= fl_rdata;
                end
            end else if (req && !done_r) begin
                en_r    <= 1'b1;
                wr_r    <= wr;
                addr_r  <= addr;
                wdata_r <= wdata;
            end
        end
    end

    assign fl_en    = en_r;
    assign fl_wr    = wr_r;
    assign fl_addr  = addr_r;
    assign fl_wdata = wdata_r;
    assign done     = done_r;
    assign rdata    = rdata_r;

endmodule

// File: rtl/flash_reader.sv
// SPI NOR read sequencer. Initialises the SB_SPI block, then per request
// drops CS, sends READ + 24-bit address, clocks out i_len bytes onto a
// valid/ready stream and raises CS again. Status polls are bounded by
// POLL_LIMIT; exhausting it aborts the transfer with a sticky error.
module flash_reader
    import flash_reader_pkg::*;
#(
    parameter int         POLL_LIMIT = 1024,
    parameter logic [7:0] CMD_READ   = 8'h03
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [23:0] i_addr,
    input  logic [15:0] i_len,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic        o_valid,
    output logic [7:0]  o_data,
    input  logic        i_ready,
    output logic        o_fl_en,
    output logic        o_fl_wr,
    output logic [3:0]  o_fl_addr,
    output logic [7:0]  o_fl_wdata,
    input  logic        i_fl_ack,
    input  logic [7:0]  i_fl_rdata
);

    localparam int            PW        = $clog2(POLL_LIMIT + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_LIMIT - 1);

    state_e        state_r;
    state_e        next_state_s;
    state_e        ret_r;
    logic [23:0]   addr_r;
    logic [15:0]   remain_r;
    logic [7:0]    tx_byte_r;
    logic [1:0]    hdr_idx_r;
    logic [PW-1:0] poll_cnt_r;

    logic          o_busy_r;
    logic          o_done_r;
    logic          o_err_r;
    logic          o_valid_r;
    logic [7:0]    o_data_r;

    logic          req_s;
    logic          wr_s;
    logic [3:0]    reg_addr_s;
    logic [7:0]    wdata_s;
    logic          port_done_s;
    logic [7:0]    port_rdata_s;

    logic          start_accept_s;
    logic          start_ok_s;
    logic          zero_start_s;
    logic          polling_s;
    logic          poll_hit_s;
    logic          poll_last_s;
    logic          abort_s;

    assign start_accept_s = (state_r == ST_IDLE) && i_start;
    assign start_ok_s     = start_accept_s && (i_len != 16'd0);
    assign zero_start_s   = start_accept_s && (i_len == 16'd0);
    assign polling_s      = (state_r == ST_POLL_T) || (state_r == ST_POLL_R);
    assign poll_hit_s     = (state_r == ST_POLL_T) ? port_rdata_s[SR_TRDY] : port_rdata_s[SR_RRDY];
    assign poll_last_s    = (poll_cnt_r == POLL_LAST);
    assign abort_s        = polling_s && port_done_s && !poll_hit_s && poll_last_s;

    flash_reg_port u_port (
        .clk      (i_clk),
        .rst      (i_rst),
        .req      (req_s),
        .wr       (wr_s),
        .addr     (reg_addr_s),
        .wdata    (wdata_s),
        .done     (port_done_s),
        .rdata    (port_rdata_s),
        .fl_en    (o_fl_en),
        .fl_wr    (o_fl_wr),
        .fl_addr  (o_fl_addr),
        .fl_wdata (o_fl_wdata),
        .fl_ack   (i_fl_ack),
        .fl_rdata (i_fl_rdata)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= ST_INIT_CR1;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: each bus step advances when the access engine reports done
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_INIT_CR1: begin
                if (port_done_s) next_state_s = ST_INIT_CSR;
                else             next_state_s = ST_INIT_CR1;
            end
            ST_INIT_CSR: begin
                if (port_done_s) next_state_s = ST_IDLE;
                else             next_state_s = ST_INIT_CSR;
            end
            ST_IDLE: begin
                if (start_ok_s) next_state_s = ST_CS_LO;
                else            next_state_s = ST_IDLE;
            end
            ST_CS_LO: begin
                if (port_done_s) next_state_s = ST_POLL_T;
                else             next_state_s = ST_CS_LO;
            end
            ST_POLL_T: begin
                if (!port_done_s)    next_state_s = ST_POLL_T;
                else if (poll_hit_s) next_state_s = ST_TX;
                else if (abort_s)    next_state_s = ST_CS_HI;
                else                 next_state_s = ST_POLL_T;
            end
            ST_TX: begin
                if (port_done_s) next_state_s = ST_POLL_R;
                else             next_state_s = ST_TX;
            end
            ST_POLL_R: begin
                if (!port_done_s)    next_state_s = ST_POLL_R;
                else if (poll_hit_s) next_state_s = ST_RX;
                else if (abort_s)    next_state_s = ST_CS_HI;
                else                 next_state_s = ST_POLL_R;
            end
            ST_RX: begin
                if (port_done_s) next_state_s = ret_r;
                else             next_state_s = ST_RX;
            end
            ST_NEXT: begin
                next_state_s = ST_POLL_T;
            end
            ST_VALID: begin
                if (!i_ready)                   next_state_s = ST_VALID;
                else if (remain_r == 16'd1)     next_state_s = ST_CS_HI;
                else                            next_state_s = ST_POLL_T;
            end
            ST_CS_HI: begin
                if (port_done_s) next_state_s = ST_IDLE;
                else             next_state_s = ST_CS_HI;
            end
            default: begin
                next_state_s = ST_INIT_CR1;
            end
        endcase
    end

    // Output logic: register-bus request for the current state
    always_comb begin
        req_s      = 1'b0;
        wr_s       = 1'b0;
        reg_addr_s = 4'h0;
        wdata_s    = 8'h00;
        case (state_r)
            ST_INIT_CR1: begin
                req_s = 1'b1; wr_s = 1'b1; reg_addr_s = SPI_CR1; wdata_s = CR1_ENABLE;
            end
            ST_INIT_CSR: begin
                req_s = 1'b1; wr_s = 1'b1; reg_addr_s = SPI_CSR; wdata_s = CSR_CS_HIGH;
            end
            ST_CS_LO: begin
                req_s = 1'b1; wr_s = 1'b1; reg_addr_s = SPI_CSR; wdata_s = CSR_CS_LOW;
            end
            ST_POLL_T, ST_POLL_R: begin
                req_s = 1'b1; wr_s = 1'b0; reg_addr_s = SPI_SR; wdata_s = 8'h00;
            end
            ST_TX: begin
                req_s = 1'b1; wr_s = 1'b1; reg_addr_s = SPI_TXDR; wdata_s = tx_byte_r;
            end
            ST_RX: begin
                req_s = 1'b1; wr_s = 1'b0; reg_addr_s = SPI_RXDR; wdata_s = 8'h00;
            end
            ST_CS_HI: begin
                req_s = 1'b1; wr_s = 1'b1; reg_addr_s = SPI_CSR; wdata_s = CSR_CS_HIGH;
            end
            default: begin
                req_s = 1'b0; wr_s = 1'b0; reg_addr_s = 4'h0; wdata_s = 8'h00;
            end
        endcase
    end

    // Transfer bookkeeping: latched request, header sequencing, poll counting, remaining bytes
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_r     <= 24'h000000;
            remain_r   <= 16'd0;
            tx_byte_r  <= 8'h00;
            hdr_idx_r  <= 2'd0;
            ret_r      <= ST_NEXT;
            poll_cnt_r <= {PW{1'b0}};
        end else begin
            if (!polling_s) begin
                poll_cnt_r <= {PW{1'b0}};
            end
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        addr_r    <= i_addr;
                        remain_r  <= i_len;
                        tx_byte_r <= CMD_READ;
                        hdr_idx_r <= 2'd0;
                        ret_r     <= ST_NEXT;
                    end
                end
                ST_POLL_T, ST_POLL_R: begin
                    if (port_done_s) begin
                        if (poll_hit_s) poll_cnt_r <= {PW{1'b0}};
                        else            poll_cnt_r <= poll_cnt_r + PW'(1);
                    end
                end
                ST_NEXT: begin
                    if (hdr_idx_r == 2'd3) begin
                        tx_byte_r <= DUMMY_BYTE;
                        ret_r     <= ST_VALID;
                    end else begin
                        tx_byte_r <= addr_byte(addr_r, hdr_idx_r);
                        hdr_idx_r <= hdr_idx_r + 2'd1;
                    end
                end
                ST_VALID: begin
                    if (i_ready) remain_r <= remain_r - 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Registered user-side outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_busy_r  <= 1'b0;
            o_done_r  <= 1'b0;
            o_err_r   <= 1'b0;
            o_valid_r <= 1'b0;
            o_data_r  <= 8'h00;
        end else begin
            o_busy_r  <= (next_state_s != ST_IDLE);
            o_valid_r <= (next_state_s == ST_VALID);
            o_done_r  <= zero_start_s || ((state_r == ST_CS_HI) && port_done_s);
            if ((state_r == ST_RX) && port_done_s && (ret_r == ST_VALID)) begin
                o_data_r <= port_rdata_s;
            end
            if (start_accept_s) begin
                o_err_r <= 1'b0;
            end else if (abort_s) begin
                o_err_r <= 1'b1;
            end
        end
    end

    assign o_busy  = o_busy_r;
    assign o_done  = o_done_r;
    assign o_err   = o_err_r;
    assign o_valid = o_valid_r;
    assign o_data  = o_data_r;

endmodule

// File: tb/tb_flash_reader.sv
// Directed bench for flash_reader: behavioural SB_SPI register-bus model
// with an attached SPI NOR whose byte at address i reads as i & 8'hFF.
module tb_flash_reader;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [23:0] i_addr;
    logic [15:0] i_len;
    logic        o_busy, o_done, o_err, o_valid;
    logic [7:0]  o_data;
    logic        i_ready;
    logic        o_fl_en, o_fl_wr;
    logic [3:0]  o_fl_addr;
    logic [7:0]  o_fl_wdata;
    logic        ack_m = 1'b0;
    logic [7:0]  rdata_m = 8'h00;

    int errors = 0;
    int checks = 0;

    flash_reader #(.POLL_LIMIT(16), .CMD_READ(8'h03)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_addr(i_addr), .i_len(i_len),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_valid(o_valid), .o_data(o_data),
        .i_ready(i_ready), .o_fl_en(o_fl_en), .o_fl_wr(o_fl_wr), .o_fl_addr(o_fl_addr),
        .o_fl_wdata(o_fl_wdata), .i_fl_ack(ack_m), .i_fl_rdata(rdata_m)
    );

    always #5 clk = ~clk;

    // ---------------- flash register-bus + SPI NOR model ----------------
    logic        hold_trdy0 = 1'b0;
    int          sr_reads = 0, txdr_cnt = 0, acc_cnt = 0;
    logic [11:0] wlog[$];
    logic        cs_low_m = 1'b0;
    int          spi_cnt_m = 0;
    logic [23:0] fa_m = 24'h0;
    logic [7:0]  rx_m = 8'h00;

    always @(posedge clk) begin
        if (i_rst) begin
            ack_m <= 1'b0;
        end else if (o_fl_en && !ack_m) begin
            ack_m   <= 1'b1;
            acc_cnt <= acc_cnt + 1;
            rdata_m <= 8'h00;
            if (o_fl_wr) begin
                wlog.push_back({o_fl_addr, o_fl_wdata});
                if (o_fl_addr == 4'hF) begin
                    cs_low_m <= ~o_fl_wdata[0];
                    if (o_fl_wdata[0]) spi_cnt_m <= 0;
                end else if (o_fl_addr == 4'hD) begin
                    txdr_cnt <= txdr_cnt + 1;
                    if (cs_low_m) begin
                        spi_cnt_m <= spi_cnt_m + 1;
                        case (spi_cnt_m)
                            0: rx_m <= 8'hFF;
                            1: begin fa_m[23:16] <= o_fl_wdata; rx_m <= 8'hFF; end
                            2: begin fa_m[15:8]  <= o_fl_wdata; rx_m <= 8'hFF; end
                            3: begin fa_m[7:0]   <= o_fl_wdata; rx_m <= 8'hFF; end
                            default: rx_m <= fa_m[7:0] + 8'(spi_cnt_m - 4);
                        endcase
                    end
                end
            end else if (o_fl_addr == 4'hC) begin
                sr_reads <= sr_reads + 1;
                rdata_m  <= {3'b000, ~hold_trdy0, 1'b1, 3'b000};
            end else if (o_fl_addr == 4'hE) begin
                rdata_m <= rx_m;
            end
        end else begin
            ack_m <= 1'b0;
        end
    end

    // ---------------- bus handshake monitor ----------------
    int          proto_err = 0;
    logic        en_q = 1'b0, ack_q = 1'b0, wr_q = 1'b0, rst_q = 1'b1;
    logic [3:0]  addr_q = 4'h0;
    logic [7:0]  wd_q = 8'h00;

    always @(posedge clk) begin
        if (!i_rst && !rst_q && en_q) begin
            if (!ack_q) begin
                if (!(o_fl_en && o_fl_wr == wr_q && o_fl_addr == addr_q && o_fl_wdata == wd_q))
                    proto_err <= proto_err + 1;
            end else if (o_fl_en) begin
                proto_err <= proto_err + 1;
            end
        end
        en_q   <= o_fl_en;
        ack_q  <= ack_m;
        wr_q   <= o_fl_wr;
        addr_q <= o_fl_addr;
        wd_q   <= o_fl_wdata;
        rst_q  <= i_rst;
    end

    // ---------------- helpers (no comparisons) ----------------
    logic [7:0] got_q[$];
    int         done_cnt;
    int         valid_cnt;
    bit         to_flag;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic [23:0] a, input logic [15:0] n);
        i_addr  = a;
        i_len   = n;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        to_flag = 1'b1;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (!o_busy) begin
                to_flag = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_until_done(input int budget);
        got_q.delete();
        done_cnt  = 0;
        valid_cnt = 0;
        to_flag   = 1'b1;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (o_valid) valid_cnt++;
            if (o_valid && i_ready) got_q.push_back(o_data);
            if (o_done) begin
                done_cnt++;
                to_flag = 1'b0;
                break;
            end
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            if (o_done) done_cnt++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [11:0] exp_w [2];
        exp_w = '{{4'h9, 8'h80}, {4'hF, 8'hFF}};
        i_rst = 1'b1; i_start = 1'b0; i_addr = 24'h0; i_len = 16'd0; i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_busy, o_done, o_err, o_valid, o_data, o_fl_en, o_fl_wr, o_fl_addr, o_fl_wdata} !== 26'h0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b valid=%b data=%h en=%b wr=%b addr=%h wdata=%h, want all 0",
                     o_busy, o_done, o_err, o_valid, o_data, o_fl_en, o_fl_wr, o_fl_addr, o_fl_wdata);
        end
        i_rst = 1'b0;
        tick();
        tick();
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL init_busy: got %b want 1", o_busy); end
        wait_idle(200);
        checks++;
        if (to_flag !== 1'b0) begin errors++; $display("FAIL init_timeout: busy never fell"); end
        checks++;
        if (wlog.size() !== 2) begin errors++; $display("FAIL init_write_count: got %0d want 2", wlog.size()); end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (wlog[i] !== exp_w[i]) begin errors++; $display("FAIL init_write%0d: got %h want %h", i, wlog[i], exp_w[i]); end
        end
    endtask

    task automatic test_read4();
        logic [11:0] exp_w [10];
        exp_w = '{{4'hF, 8'hFE}, {4'hD, 8'h03}, {4'hD, 8'h00}, {4'hD, 8'h00}, {4'hD, 8'h10},
                  {4'hD, 8'h00}, {4'hD, 8'h00}, {4'hD, 8'h00}, {4'hD, 8'h00}, {4'hF, 8'hFF}};
        wlog.delete();
        i_ready = 1'b1;
        start_req(24'h000010, 16'd4);
        run_until_done(3000);
        checks++;
        if (to_flag !== 1'b0) begin errors++; $display("FAIL read4_timeout: no o_done"); end
        checks++;
        if (got_q.size() !== 4) begin errors++; $display("FAIL read4_count: got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== 8'(8'h10 + i)) begin errors++; $display("FAIL read4_byte%0d: got %h want %h", i, got_q[i], 8'(8'h10 + i)); end
        end
        checks++;
        if (wlog.size() !== 10) begin errors++; $display("FAIL read4_write_count: got %0d want 10", wlog.size()); end
        for (int i = 0; i < 10 && i < wlog.size(); i++) begin
            checks++;
            if (wlog[i] !== exp_w[i]) begin errors++; $display("FAIL read4_write%0d: got %h want %h", i, wlog[i], exp_w[i]); end
        end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL read4_done_pulses: got %0d want 1", done_cnt); end
        checks++;
        if (o_err !== 1'b0) begin errors++; $display("FAIL read4_err: got %b want 0", o_err); end
    endtask

    task automatic test_backpressure();
        int         tx0;
        int         bad;
        logic [7:0] d;
        bit         lost;
        tx0 = txdr_cnt;
        lost = 1'b0;
        i_ready = 1'b0;
        start_req(24'h000020, 16'd3);
        for (int k = 0; k < 3 && !lost; k++) begin
            lost = 1'b1;
            for (int c = 0; c < 500; c++) begin
                if (o_valid) begin lost = 1'b0; break; end
                tick();
            end
            checks++;
            if (lost) begin errors++; $display("FAIL bp_valid_timeout: byte %0d never valid", k); end
            else begin
                d = o_data;
                checks++;
                if (d !== 8'(8'h20 + k)) begin errors++; $display("FAIL bp_byte%0d: got %h want %h", k, d, 8'(8'h20 + k)); end
                bad = 0;
                for (int c = 0; c < 20; c++) begin
                    tick();
                    if (o_valid !== 1'b1 || o_data !== d) bad++;
                end
                checks++;
                if (bad !== 0) begin errors++; $display("FAIL bp_stable%0d: got %0d unstable cycles want 0", k, bad); end
                checks++;
                if (txdr_cnt - tx0 !== 5 + k) begin errors++; $display("FAIL bp_txdr%0d: got %0d writes want %0d", k, txdr_cnt - tx0, 5 + k); end
                i_ready = 1'b1;
                tick();
                i_ready = 1'b0;
            end
        end
        to_flag = 1'b1;
        for (int c = 0; c < 500; c++) begin
            if (o_done) begin to_flag = 1'b0; break; end
            tick();
        end
        checks++;
        if (to_flag !== 1'b0) begin errors++; $display("FAIL bp_done_timeout: no o_done"); end
        checks++;
        if (txdr_cnt - tx0 !== 7) begin errors++; $display("FAIL bp_txdr_total: got %0d want 7", txdr_cnt - tx0); end
        i_ready = 1'b1;
        tick();
    endtask

    task automatic test_len_zero();
        int acc0;
        int busy_seen;
        acc0 = acc_cnt;
        start_req(24'h000123, 16'd0);
        checks++;
        if (o_done !== 1'b1) begin errors++; $display("FAIL len0_done: got %b want 1", o_done); end
        busy_seen = 0;
        tick();
        checks++;
        if (o_done !== 1'b0) begin errors++; $display("FAIL len0_done_pulse: got %b want 0", o_done); end
        for (int c = 0; c < 10; c++) begin
            if (o_busy) busy_seen++;
            tick();
        end
        checks++;
        if (acc_cnt - acc0 !== 0) begin errors++; $display("FAIL len0_bus: got %0d accesses want 0", acc_cnt - acc0); end
        checks++;
        if (busy_seen !== 0) begin errors++; $display("FAIL len0_busy: got %0d busy cycles want 0", busy_seen); end
    endtask

    task automatic test_timeout();
        int sr0;
        int tx0;
        sr0 = sr_reads;
        tx0 = txdr_cnt;
        wlog.delete();
        hold_trdy0 = 1'b1;
        start_req(24'h000000, 16'd2);
        run_until_done(2000);
        checks++;
        if (to_flag !== 1'b0) begin errors++; $display("FAIL to_done_timeout: no o_done"); end
        checks++;
        if (o_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", o_err); end
        checks++;
        if (sr_reads - sr0 !== 16) begin errors++; $display("FAIL to_polls: got %0d want 16", sr_reads - sr0); end
        checks++;
        if (txdr_cnt - tx0 !== 0) begin errors++; $display("FAIL to_txdr: got %0d want 0", txdr_cnt - tx0); end
        checks++;
        if (wlog.size() !== 2 || wlog[wlog.size() - 1] !== {4'hF, 8'hFF}) begin
            errors++; $display("FAIL to_cs_high: got %0d writes, last %h, want 2 ending fff", wlog.size(), wlog[wlog.size() - 1]);
        end
        checks++;
        if (valid_cnt !== 0) begin errors++; $display("FAIL to_valid: got %0d valid cycles want 0", valid_cnt); end
        repeat (5) tick();
        checks++;
        if (o_err !== 1'b1) begin errors++; $display("FAIL to_err_sticky: got %b want 1", o_err); end
        hold_trdy0 = 1'b0;
        start_req(24'h000005, 16'd1);
        checks++;
        if (o_err !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b want 0", o_err); end
        run_until_done(2000);
        checks++;
        if (got_q.size() !== 1 || got_q[0] !== 8'h05) begin
            errors++; $display("FAIL to_recover: got %0d bytes first %h want 1 byte 05", got_q.size(), got_q[0]);
        end
    endtask

    task automatic test_reset_mid_data();
        int hs;
        logic [11:0] exp_w [2];
        exp_w = '{{4'h9, 8'h80}, {4'hF, 8'hFF}};
        i_ready = 1'b1;
        hs = 0;
        start_req(24'h000040, 16'd8);
        for (int c = 0; c < 2000 && hs < 2; c++) begin
            tick();
            if (o_valid && i_ready) hs++;
        end
        repeat (3) tick();
        checks++;
        if (hs !== 2 || o_busy !== 1'b1) begin errors++; $display("FAIL mid_precond: got hs=%0d busy=%b want 2,1", hs, o_busy); end
        i_rst = 1'b1;
        #1;
        checks++;
        if ({o_busy, o_done, o_err, o_valid, o_data, o_fl_en, o_fl_wr, o_fl_addr, o_fl_wdata} !== 26'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got busy=%b valid=%b data=%h en=%b addr=%h, want all 0",
                     o_busy, o_valid, o_data, o_fl_en, o_fl_addr);
        end
        repeat (2) @(posedge clk);
        #1;
        wlog.delete();
        i_rst = 1'b0;
        wait_idle(200);
        checks++;
        if (to_flag !== 1'b0 || wlog.size() !== 2) begin errors++; $display("FAIL mid_init: got %0d writes want 2", wlog.size()); end
        for (int i = 0; i < 2 && i < wlog.size(); i++) begin
            checks++;
            if (wlog[i] !== exp_w[i]) begin errors++; $display("FAIL mid_init_write%0d: got %h want %h", i, wlog[i], exp_w[i]); end
        end
        start_req(24'h000030, 16'd2);
        run_until_done(2000);
        checks++;
        if (got_q.size() !== 2 || got_q[0] !== 8'h30 || got_q[1] !== 8'h31) begin
            errors++; $display("FAIL mid_restart: got %0d bytes %h %h want 30 31", got_q.size(), got_q[0], got_q[1]);
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (proto_err !== 0) begin errors++; $display("FAIL bus_protocol: got %0d violations want 0", proto_err); end
    endtask

    initial begin
        test_reset();
        test_read4();
        test_backpressure();
        test_len_zero();
        test_timeout();
        test_reset_mid_data();
        test_protocol();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
